// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM -> WB pipeline handshake and payload bundle.
//   master : MEM side, drives the valid flag and instruction payload
//   slave  : WB side, returns ws_allowin
interface wb_stage_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        ms_csr_re;
  logic        ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask;
  logic [31:0] ms_csr_wvalue;
  logic        ms_ertn;
  logic [5:0]  ms_exc;      // [0] INT [1] ADEF [2] INE [3] SYS [4] BRK [5] ALE
  logic [31:0] ms_vaddr;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_re,
           ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_ertn,
           ms_exc, ms_vaddr,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_re,
           ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_ertn,
           ms_exc, ms_vaddr,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage LoongArch pipeline.
// Registers one instruction from MEM, commits its GPR write, prioritises
// exception flags into ecode/esubcode, drives the CSR file commit inputs,
// raises the pipeline flush and provides forwarding/hazard taps and trace.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ms                  MEM -> WB bundle (wb_stage_if.slave)
//   csr_rvalue          combinational CSR read data
//   csr_*               CSR file read/write strobes, number, mask, value
//   wb_ex, ertn_flush   exception / ertn commit; wb_ecode, wb_esubcode
//   wb_pc, wb_vaddr     committing PC and faulting data address
//   ws_flush            flush of all upstream stages
//   rf_*                GPR write port
//   ws_fwd_*, ws_csr_blk forwarding tap and CSR hazard hint for ID
//   debug_wb_*          trace (zero when TRACE_EN=0)
module wb_stage #(
  parameter bit TRACE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   ms,
  input  logic [31:0] csr_rvalue,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ws_flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] ws_fwd_data,
  output logic        ws_csr_blk,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic [5:0]  exc;
    logic [31:0] vaddr;
  } ws_pl_t;

  logic   ws_valid_q, ws_valid_d;
  ws_pl_t pl_q, pl_d;
  logic   ws_valid, has_exc, any_exc;
  logic [5:0] ecode;

  // Single-cycle stage, never stalls.
  assign ms.ws_allowin = 1'b1;

  // The reset cycle commits nothing, even though the flop still holds valid.
  assign ws_valid = ws_valid_q & ~reset;
  assign has_exc  = |pl_q.exc;
  assign any_exc  = ws_valid & has_exc;

  always_comb begin
    ws_valid_d = ms.ms_to_ws_valid & ~ws_flush;
    pl_d       = pl_q;
    if (ms.ms_to_ws_valid && ms.ws_allowin) begin
      pl_d.pc         = ms.ms_pc;
      pl_d.gr_we      = ms.ms_gr_we;
      pl_d.dest       = ms.ms_dest;
      pl_d.result     = ms.ms_result;
      pl_d.csr_re     = ms.ms_csr_re;
      pl_d.csr_we     = ms.ms_csr_we;
      pl_d.csr_num    = ms.ms_csr_num;
      pl_d.csr_wmask  = ms.ms_csr_wmask;
      pl_d.csr_wvalue = ms.ms_csr_wvalue;
      pl_d.ertn       = ms.ms_ertn;
      pl_d.exc        = ms.ms_exc;
      pl_d.vaddr      = ms.ms_vaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      pl_q       <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      pl_q       <= pl_d;
    end
  end

  // Lowest flag index has highest priority.
  always_comb begin
    ecode = 6'h00;
    if (any_exc) begin
      if      (pl_q.exc[0]) ecode = ECODE_INT;
      else if (pl_q.exc[1]) ecode = ECODE_ADEF;
      else if (pl_q.exc[2]) ecode = ECODE_INE;
      else if (pl_q.exc[3]) ecode = ECODE_SYS;
      else if (pl_q.exc[4]) ecode = ECODE_BRK;
      else                  ecode = ECODE_ALE;
    end
  end

  assign wb_ecode    = ecode;
  assign wb_esubcode = 9'h000;
  assign wb_ex       = any_exc;
  // An exception in the same instruction overrides ertn and CSR writes.
  assign ertn_flush  = ws_valid & pl_q.ertn & ~has_exc;
  assign csr_we      = ws_valid & pl_q.csr_we & ~has_exc;
  assign csr_re      = ws_valid & pl_q.csr_re;
  assign csr_num     = pl_q.csr_num;
  assign csr_wmask   = pl_q.csr_wmask;
  assign csr_wvalue  = pl_q.csr_wvalue;
  assign ws_flush    = wb_ex | ertn_flush;
  assign wb_pc       = pl_q.pc;
  assign wb_vaddr    = pl_q.vaddr;

  assign rf_we    = ws_valid & pl_q.gr_we & ~has_exc & (pl_q.dest != 5'd0);
  assign rf_waddr = pl_q.dest;
  // CSR read data is sampled before the CSR file updates at the edge,
  // so csrwr/csrxchg naturally return the old value.
  assign rf_wdata = pl_q.csr_re ? csr_rvalue : pl_q.result;

  assign ws_fwd_valid = rf_we;
  assign ws_fwd_dest  = rf_waddr;
  assign ws_fwd_data  = rf_wdata;
  assign ws_csr_blk   = ws_valid & (pl_q.csr_we | pl_q.ertn | has_exc);

  generate
    if (TRACE_EN) begin : g_trace
      assign debug_wb_pc       = pl_q.pc;
      assign debug_wb_rf_we    = {4{rf_we}};
      assign debug_wb_rf_wnum  = rf_waddr;
      assign debug_wb_rf_wdata = rf_wdata;
    end else begin : g_no_trace
      assign debug_wb_pc       = 32'h0;
      assign debug_wb_rf_we    = 4'h0;
      assign debug_wb_rf_wnum  = 5'h0;
      assign debug_wb_rf_wdata = 32'h0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed + random bench for wb_stage against a cycle-level
// reference model of the instruction sitting in WB.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] csr_rvalue;
  logic        csr_re, csr_we, wb_ex, ertn_flush, ws_flush, rf_we;
  logic        ws_fwd_valid, ws_csr_blk;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, wb_pc, wb_vaddr, rf_wdata, ws_fwd_data;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [4:0]  rf_waddr, ws_fwd_dest, debug_wb_rf_wnum;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;

  wb_stage_if ms ();

  wb_stage #(.TRACE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ms(ms), .csr_rvalue(csr_rvalue),
    .csr_re(csr_re), .csr_we(csr_we), .csr_num(csr_num),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .ws_flush(ws_flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .ws_fwd_valid(ws_fwd_valid),
    .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .ws_csr_blk(ws_csr_blk), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        ertn;
    logic [5:0]  exc;
    logic [31:0] vaddr;
  } ins_t;

  ins_t cur;  // instruction presented by MEM this cycle
  ins_t m;    // model: instruction held in WB (m.valid = WB valid)
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Cause table in priority order: INT ADEF INE SYS BRK ALE.
  function automatic logic [5:0] ref_ecode(input logic [5:0] exc);
    logic [5:0] codes [6];
    codes = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
    for (int i = 0; i < 6; i++)
      if (exc[i]) return codes[i];
    return 6'h00;
  endfunction

  function automatic logic ref_flush();
    logic v;
    v = m.valid && !rst;
    return v && (m.exc != 0 || m.ertn);
  endfunction

  task automatic apply();
    reset                = rst;
    ms.ms_to_ws_valid    = cur.valid;
    ms.ms_pc             = cur.pc;
    ms.ms_gr_we          = cur.gr_we;
    ms.ms_dest           = cur.dest;
    ms.ms_result         = cur.result;
    ms.ms_csr_re         = cur.csr_re;
    ms.ms_csr_we         = cur.csr_we;
    ms.ms_csr_num        = cur.csr_num;
    ms.ms_csr_wmask      = cur.wmask;
    ms.ms_csr_wvalue     = cur.wvalue;
    ms.ms_ertn           = cur.ertn;
    ms.ms_exc            = cur.exc;
    ms.ms_vaddr          = cur.vaddr;
  endtask

  task automatic check_all();
    logic v, exc_any, e_rfwe;
    logic [31:0] e_wdata;
    v       = m.valid && !rst;
    exc_any = (m.exc != 0);
    e_rfwe  = v && m.gr_we && !exc_any && (m.dest != 0);
    e_wdata = m.csr_re ? csr_rvalue : m.result;
    chk("allowin",   ms.ws_allowin, 1);
    chk("wb_ex",     wb_ex, v && exc_any);
    chk("ecode",     wb_ecode, (v && exc_any) ? ref_ecode(m.exc) : 6'h0);
    chk("esubcode",  wb_esubcode, 0);
    chk("ertn",      ertn_flush, v && m.ertn && !exc_any);
    chk("flush",     ws_flush, ref_flush());
    chk("csr_we",    csr_we, v && m.csr_we && !exc_any);
    chk("csr_re",    csr_re, v && m.csr_re);
    chk("csr_num",   csr_num, m.csr_num);
    chk("csr_wmask", csr_wmask, m.wmask);
    chk("csr_wval",  csr_wvalue, m.wvalue);
    chk("wb_pc",     wb_pc, m.pc);
    chk("wb_vaddr",  wb_vaddr, m.vaddr);
    chk("rf_we",     rf_we, e_rfwe);
    chk("rf_waddr",  rf_waddr, m.dest);
    chk("rf_wdata",  rf_wdata, e_wdata);
    chk("fwd_v",     ws_fwd_valid, e_rfwe);
    chk("fwd_dest",  ws_fwd_dest, m.dest);
    chk("fwd_data",  ws_fwd_data, e_wdata);
    chk("csr_blk",   ws_csr_blk, v && (m.csr_we || m.ertn || exc_any));
    chk("dbg_pc",    debug_wb_pc, m.pc);
    chk("dbg_we",    debug_wb_rf_we, e_rfwe ? 4'hf : 4'h0);
    chk("dbg_wnum",  debug_wb_rf_wnum, m.dest);
    chk("dbg_wdata", debug_wb_rf_wdata, e_wdata);
  endtask

  // Model advance at the clock edge (uses pre-edge state for the flush).
  task automatic update();
    logic fl;
    fl = ref_flush();
    if (rst) begin
      m = '0;
    end else begin
      if (cur.valid) m = cur;
      m.valid = cur.valid && !fl;
    end
  endtask

  task automatic step();
    apply();
    #1;
    check_all();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] dest,
                              input logic [31:0] res, input logic [5:0] exc);
    ins_t t;
    t        = '0;
    t.valid  = 1'b1;
    t.pc     = pc;
    t.gr_we  = 1'b1;
    t.dest   = dest;
    t.result = res;
    t.exc    = exc;
    return t;
  endfunction

  ins_t bubble;

  initial begin
    m = '0; m.valid = 1'b1;   // unknown before reset; overwritten by reset
    bubble = '0;
    cur = '0; rst = 1'b1; csr_rvalue = 32'h0;
    apply();
    @(negedge clk);
    @(posedge clk); m = '0;
    @(negedge clk);
    step();                     // reset held: all outputs zero
    rst = 1'b0;

    // add
    cur = mk(32'h1c000000, 5'd5, 32'h1234, 6'h0); step();
    chk("add_we", rf_we, 1); chk("add_waddr", rf_waddr, 5);
    chk("add_wdata", rf_wdata, 32'h1234); chk("add_dbgwe", debug_wb_rf_we, 4'hf);

    // csrrd 0x0
    cur = mk(32'h1c000004, 5'd6, 32'hdead, 6'h0); cur.csr_re = 1'b1;
    csr_rvalue = 32'h8; step();
    chk("csrrd_wdata", rf_wdata, 32'h8); chk("csrrd_re", csr_re, 1);
    chk("csrrd_we", csr_we, 0);

    // csrwr with INE
    cur = mk(32'h1c000008, 5'd7, 32'h0, 6'b000100);
    cur.csr_re = 1'b1; cur.csr_we = 1'b1; cur.csr_num = 14'h5;
    cur.wmask = 32'hffffffff; cur.wvalue = 32'h55; step();
    chk("ine_ex", wb_ex, 1); chk("ine_ecode", wb_ecode, 6'h0D);
    chk("ine_csrwe", csr_we, 0); chk("ine_rfwe", rf_we, 0);
    chk("ine_flush", ws_flush, 1);
    cur = mk(32'h1c00000c, 5'd9, 32'h99, 6'h0); step();   // flushed
    chk("flushed_we", rf_we, 0); chk("flushed_ex", wb_ex, 0);

    // priority
    cur = mk(32'h1c000010, 5'd1, 32'h0, 6'b100011); step();
    chk("prio_int", wb_ecode, 6'h00); chk("prio_int_ex", wb_ex, 1);
    cur = bubble; step();
    cur = mk(32'h1c000014, 5'd1, 32'h0, 6'b100010); step();
    chk("prio_adef", wb_ecode, 6'h08);
    cur = bubble; step();
    cur = mk(32'h1c000018, 5'd1, 32'h0, 6'b100000); cur.vaddr = 32'h1003; step();
    chk("ale_ecode", wb_ecode, 6'h09); chk("ale_vaddr", wb_vaddr, 32'h1003);
    cur = bubble; step();

    // ertn
    cur = mk(32'h1c00001c, 5'd0, 32'h0, 6'h0); cur.gr_we = 1'b0; cur.ertn = 1'b1; step();
    chk("ertn_fl", ertn_flush, 1); chk("ertn_wsfl", ws_flush, 1);
    chk("ertn_ex", wb_ex, 0); chk("ertn_blk", ws_csr_blk, 1);
    cur = bubble; step();

    // dest=0 back to back
    for (int i = 0; i < 3; i++) begin
      cur = mk(32'h1c000020 + 4*i, 5'd0, 32'h77 + i, 6'h0); step();
      chk("r0_we", rf_we, 0);
    end

    // reset mid-stream with pending exception in WB
    cur = mk(32'h1c000030, 5'd3, 32'h1, 6'b001000); step();
    chk("pre_rst_ex", wb_ex, 1);
    rst = 1'b1; apply(); #1;
    chk("rst_cycle_ex", wb_ex, 0); chk("rst_cycle_we", rf_we, 0);
    step();
    rst = 1'b0; cur = bubble; apply(); #1;
    chk("post_rst_ex", wb_ex, 0); chk("post_rst_pc", wb_pc, 0);
    chk("post_rst_blk", ws_csr_blk, 0);
    step();

    // random
    for (int n = 0; n < 3000; n++) begin
      cur.valid  = ($urandom_range(0, 3) != 0);
      cur.pc     = $urandom;
      cur.gr_we  = $urandom_range(0, 1);
      cur.dest   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cur.result = $urandom;
      cur.csr_re = ($urandom_range(0, 3) == 0);
      cur.csr_we = ($urandom_range(0, 3) == 0);
      cur.csr_num = 14'($urandom);
      cur.wmask  = $urandom;
      cur.wvalue = $urandom;
      cur.ertn   = ($urandom_range(0, 9) == 0);
      cur.exc    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      cur.vaddr  = $urandom;
      csr_rvalue = $urandom;
      rst        = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
